// File: rtl/decoder_seq_pkg.sv
// Shared definitions for the decoder_seq block: controller state encoding, command mode
// encoding and a helper that maps a load command's mode onto the state it enters.
package decoder_seq_pkg;

  localparam int unsigned MODE_W = 2;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StDirect = 2'd1;
  localparam state_t StScan   = 2'd2;

  localparam logic [MODE_W-1:0] MODE_DIRECT  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SCAN_UP = 2'b01;
  localparam logic [MODE_W-1:0] MODE_SCAN_DN = 2'b10;

  // The reserved mode 2'b11 falls through to DIRECT.
  function automatic state_t mode_to_state(logic [MODE_W-1:0] mode);
    return ((mode == MODE_SCAN_UP) || (mode == MODE_SCAN_DN)) ? StScan : StDirect;
  endfunction

endpackage

// File: rtl/decoder_seq_if.sv
// Command and status bundle of decoder_seq.
//   master: drives load/stop/en/mode/sel_in/dwell, observes out/cur_sel/busy/wrap
//   slave : the decoder_seq side of the same signals
interface decoder_seq_if
  import decoder_seq_pkg::*;
#(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 4
);
  localparam int unsigned N = 2 ** SEL_W;

  logic              load;
  logic              stop;
  logic              en;
  logic [MODE_W-1:0] mode;
  logic [SEL_W-1:0]  sel_in;
  logic [DWELL_W-1:0] dwell;

  logic [N-1:0]      out;
  logic [SEL_W-1:0]  cur_sel;
  logic              busy;
  logic              wrap;

  modport master (
    output load, stop, en, mode, sel_in, dwell,
    input  out, cur_sel, busy, wrap
  );

  modport slave (
    input  load, stop, en, mode, sel_in, dwell,
    output out, cur_sel, busy, wrap
  );

endinterface

// File: rtl/decoder_onehot.sv
// Combinational index to one-hot decoder with an enable.
//   sel_i    : index to decode
//   en_i     : 0 forces an all-zero result
//   onehot_o : 2**SEL_W wide decode, at most one bit set
module decoder_onehot #(
  parameter int unsigned SEL_W = 2
) (
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  en_i,
  output logic [2**SEL_W-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_seq.sv
// Sequenced one-hot decoder. Either holds a single selected output (DIRECT) or steps the
// selection up or down through all N outputs, holding each for dwell+1 enabled cycles (SCAN).
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of decoder_seq_if (commands in, registered decode/status out)
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  decoder_seq_if.slave bus
);

  localparam int unsigned N = 2 ** SEL_W;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic               wrap_q, wrap_d;
  logic [N-1:0]       out_q, out_d;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;

    if (bus.stop) begin
      // stop takes priority over a load on the same edge; cur_sel keeps its value
      state_d = StIdle;
      cnt_d   = '0;
    end else if (bus.load) begin
      state_d = mode_to_state(bus.mode);
      sel_d   = bus.sel_in;
      dwell_d = bus.dwell;
      mode_d  = bus.mode;
      cnt_d   = '0;
    end else if ((state_q == StScan) && bus.en) begin
      if (cnt_q == dwell_q) begin
        cnt_d = '0;
        // Only SCAN_UP / SCAN_DN ever reach StScan, so anything but DN steps upward.
        if (mode_q == MODE_SCAN_DN) begin
          sel_d  = sel_q - SEL_W'(1);
          wrap_d = (sel_q == '0);
        end else begin
          sel_d  = sel_q + SEL_W'(1);
          wrap_d = (sel_q == '1);
        end
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
  end

  // Decode the next-state index so the registered output lines up with cur_sel.
  decoder_onehot #(
    .SEL_W (SEL_W)
  ) u_onehot (
    .sel_i    (sel_d),
    .en_i     (state_d != StIdle),
    .onehot_o (out_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mode_q  <= MODE_DIRECT;
      wrap_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.cur_sel = sel_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: two instances (SEL_W=2 and SEL_W=3) share the same
// command stream. After every edge a reference model pushes the expected outputs into a
// per-instance queue; a monitor on the falling edge pops and compares.
module tb_decoder_seq;

  typedef struct {
    logic [31:0] out;
    logic [31:0] sel;
    logic        busy;
    logic        wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       load, stop, en;
  logic [1:0] mode;
  logic [1:0] sel_a;
  logic [2:0] sel_b;
  logic [3:0] dwell;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  // Reference state per instance: 0 idle, 1 direct, 2 scan.
  int m_st[2];
  int m_start[2];
  int m_d[2];
  int m_k[2];
  int m_sel[2];
  bit m_up[2];
  bit m_wrap[2];

  always #5 clk = ~clk;

  decoder_seq_if #(.SEL_W(2), .DWELL_W(4)) bus2 ();
  decoder_seq_if #(.SEL_W(3), .DWELL_W(4)) bus3 ();

  assign bus2.load = load;
  assign bus2.stop = stop;
  assign bus2.en = en;
  assign bus2.mode = mode;
  assign bus2.sel_in = sel_a;
  assign bus2.dwell = dwell;
  assign bus3.load = load;
  assign bus3.stop = stop;
  assign bus3.en = en;
  assign bus3.mode = mode;
  assign bus3.sel_in = sel_b;
  assign bus3.dwell = dwell;

  decoder_seq #(.SEL_W(2), .DWELL_W(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  decoder_seq #(.SEL_W(3), .DWELL_W(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Scan position is derived from the number of enabled edges since the load:
  // index = start +/- floor(k / (dwell+1)) mod N.
  function automatic void model_edge(input int i, input bit r, input bit ld, input bit sp,
                                     input bit e, input logic [1:0] md, input int si,
                                     input int dw);
    int n;
    int q;
    exp_t ex;
    n = (i == 0) ? 4 : 8;
    m_wrap[i] = 1'b0;
    if (r) begin
      m_st[i] = 0;
      m_sel[i] = 0;
    end else if (sp) begin
      m_st[i] = 0;
    end else if (ld) begin
      m_st[i] = (md == 2'b01 || md == 2'b10) ? 2 : 1;
      m_start[i] = si;
      m_d[i] = dw;
      m_up[i] = (md == 2'b01);
      m_k[i] = 0;
      m_sel[i] = si;
    end else if (m_st[i] == 2 && e) begin
      m_k[i]++;
      q = m_k[i] / (m_d[i] + 1);
      m_sel[i] = m_up[i] ? (m_start[i] + q) % n : ((m_start[i] - q) % n + n) % n;
      m_wrap[i] = (m_k[i] % (m_d[i] + 1) == 0) && (m_sel[i] == (m_up[i] ? 0 : n - 1));
    end
    ex.out = (m_st[i] != 0) ? (32'd1 << m_sel[i]) : 32'd0;
    ex.sel = m_sel[i];
    ex.busy = (m_st[i] != 0);
    ex.wrap = m_wrap[i];
    if (i == 0) q0.push_back(ex);
    else q1.push_back(ex);
  endfunction

  task automatic step(input bit r, input bit ld, input bit sp, input bit e,
                      input logic [1:0] md, input int sa, input int sb, input int dw);
    rst = r;
    load = ld;
    stop = sp;
    en = e;
    mode = md;
    sel_a = sa[1:0];
    sel_b = sb[2:0];
    dwell = dw[3:0];
    @(posedge clk);
    model_edge(0, r, ld, sp, e, md, sa % 4, dw % 16);
    model_edge(1, r, ld, sp, e, md, sb % 8, dw % 16);
    cycle++;
    #1;
  endtask

  task automatic cmp(input string tag, input exp_t ex, input logic [31:0] o,
                     input logic [31:0] s, input logic b, input logic w);
    tests++;
    if (o !== ex.out || s !== ex.sel || b !== ex.busy || w !== ex.wrap) begin
      fails++;
      $display("FAIL %s cycle %0d: out=%0h cur_sel=%0d busy=%0b wrap=%0b, required out=%0h cur_sel=%0d busy=%0b wrap=%0b",
               tag, cycle, o, s, b, w, ex.out, ex.sel, ex.busy, ex.wrap);
    end
    tests++;
    if (b === 1'b1 ? !$onehot(o) : (o !== 32'd0)) begin
      fails++;
      $display("FAIL %s_onehot cycle %0d: out=%0h busy=%0b, required one-hot when busy else zero",
               tag, cycle, o, b);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      cmp("sel2", e0, 32'(bus2.out), 32'(bus2.cur_sel), bus2.busy, bus2.wrap);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      cmp("sel3", e1, 32'(bus3.out), 32'(bus3.cur_sel), bus3.busy, bus3.wrap);
    end
  end

  initial begin
    int dw;
    // Reset for two cycles.
    step(1, 0, 0, 0, 2'b00, 0, 0, 0);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0);
    // DIRECT on index 2, en toggling, then stop.
    step(0, 1, 0, 0, 2'b00, 2, 5, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, i % 2, 2'b00, 0, 0, 0);
    step(0, 0, 1, 0, 2'b00, 0, 0, 0);
    // SCAN_UP from 3 (and 6), dwell 1.
    step(0, 1, 0, 1, 2'b01, 3, 6, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 2'b00, 0, 0, 0);
    // SCAN_DN from 0, dwell 0, then freeze with en=0.
    step(0, 1, 0, 1, 2'b10, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 2'b00, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 2'b00, 0, 0, 0);
    // load and stop on the same edge during SCAN.
    step(0, 1, 1, 1, 2'b01, 1, 1, 0);
    // Reset in the middle of a scan, then a fresh load.
    step(0, 1, 0, 1, 2'b01, 2, 2, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 2'b00, 0, 0, 0);
    step(1, 1, 1, 1, 2'b01, 3, 3, 0);
    step(0, 0, 0, 1, 2'b00, 0, 0, 0);
    // SCAN_UP from 6 on the 8-wide instance, dwell 0.
    step(0, 1, 0, 1, 2'b01, 1, 6, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 2'b00, 0, 0, 0);
    // Retarget mid-scan with a reserved mode.
    step(0, 1, 0, 1, 2'b11, 2, 4, 3);
    step(0, 0, 0, 1, 2'b00, 0, 0, 0);
    // Randomised command stream.
    for (int i = 0; i < 3000; i++) begin
      dw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 80, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
           $urandom_range(0, 7), dw);
    end
    step(0, 0, 0, 0, 2'b00, 0, 0, 0);
    @(negedge clk);
    #1;
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain: queued=%0d/%0d, required 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter SEL_W, default 2, select width; N = 2**SEL_W one-hot outputs.
REQ-002 Parameter DWELL_W, default 4, width of the per-step dwell count.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load  input  1  start/retarget command, sampled each edge.
REQ-006 stop  input  1  return to IDLE, sampled each edge.
REQ-007 en  input  1  scan advance enable; 0 freezes dwell counter and cur_sel.
REQ-008 mode  input  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DN, 11 reserved (treated as DIRECT); sampled only when load=1.
REQ-009 sel_in  input  SEL_W  target index (DIRECT) or start index (SCAN).
REQ-010 dwell  input  DWELL_W  extra cycles held per scan step; sampled only when load=1.
REQ-011 out  output  N  registered one-hot decode of cur_sel; all-zero in IDLE.
REQ-012 cur_sel  output  SEL_W  registered current index.
REQ-013 busy  output  1  1 in DIRECT or SCAN state.
REQ-014 wrap  output  1  registered one-cycle pulse on scan wrap-around.

Function
REQ-015 States: IDLE, DIRECT, SCAN; encoding in shared package.
REQ-016 IDLE: out=0, busy=0, cur_sel holds last value.
REQ-017 Edge with load=1, stop=0: cur_sel<=sel_in, dwell latched, dwell counter<=0, state<=DIRECT or SCAN per mode; out = one-hot of sel_in in the cycle after that edge (latency 1).
REQ-018 load while DIRECT or SCAN retargets identically; the in-progress dwell count is discarded.
REQ-019 DIRECT: out holds one-hot(cur_sel) until stop or load; en ignored.
REQ-020 SCAN, en=1: counter increments each edge; at edge where counter==dwell latched value, counter<=0 and cur_sel<=cur_sel+1 (UP) or -1 (DN) modulo N; each index held dwell+1 cycles.
REQ-021 dwell=0: cur_sel advances on every enabled edge.
REQ-022 wrap=1 for exactly the cycle following an advance N-1->0 (UP) or 0->N-1 (DN); else 0.
REQ-023 SCAN, en=0: counter, cur_sel, out frozen; wrap=0.
REQ-024 stop=1 at any edge: state<=IDLE, out<=0, wrap<=0, counter<=0; stop wins over simultaneous load.
REQ-025 out is always exactly one-hot when busy=1 and all-zero when busy=0; never multi-hot.
REQ-026 Index arithmetic is SEL_W bits, unsigned, natural modulo-N wrap; counter DWELL_W bits, cannot overflow since compared against latched dwell.

Reset
REQ-027 rst=1 at an edge: state IDLE, out=0, cur_sel=0, busy=0, wrap=0, counter=0, latched mode/dwell=0; rst overrides load and stop.
REQ-028 rst mid-scan aborts immediately; first post-reset load behaves as from power-up.

Structure
REQ-029 Shared package holds state enum, mode encoding constants (MODE_DIRECT, MODE_SCAN_UP, MODE_SCAN_DN).
REQ-030 One sub-module: decoder_onehot (parametrised SEL_W combinational index->one-hot with enable), its output registered in decoder_seq.

Verification (SEL_W=2 unless noted)
REQ-031 rst for 2 cycles -> out=0000, cur_sel=0, busy=0, wrap=0.
REQ-032 load, mode=DIRECT, sel_in=2 -> next cycle out=0100, busy=1; held 10 cycles with en toggling; stop -> out=0000.
REQ-033 load, SCAN_UP, sel_in=3, dwell=1, en=1 -> out 1000,1000,0001,0001,0010,0010...; wrap=1 only on first 0001 cycle.
REQ-034 load, SCAN_DN, sel_in=0, dwell=0 -> out 0001,1000,0100,0010,0001; wrap=1 on the 1000 cycle; en=0 for 3 cycles freezes out.
REQ-035 load and stop same edge during SCAN -> IDLE, out=0000; rst mid-scan -> reset values next cycle.
REQ-036 SEL_W=3, SCAN_UP from 6, dwell=0 -> out 0x40,0x80,0x01 with wrap on 0x01; one-hot check every cycle.
